id_decode_stage: RTL
====================

Name: id_decode_stage

Overview:
- IF/ID pipeline stage with a 2-entry skid buffer.
- Accepts fetched instruction words plus PC from the fetch stage over a valid/ready handshake.
- Registers the decoded fields and classifies the immediate format.
- Drives the immediate generator's raw field (instr[31:7]) and its 3-bit format select; also supplies register indices, funct fields and PC to the execute stage.

Parameters:
- XLEN, 32, datapath/PC width
- INST, 25, width of raw immediate field (instr[31:7])

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  synchronous active-low reset
- flush_i  in  1  discard all buffered instructions (branch/jump redirect)
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  stage can accept an instruction
- if_inst_i  in  32  instruction word
- if_pc_i  in  XLEN  PC of instruction
- id_valid_o  out  1  decoded instruction valid
- id_ready_i  in  1  execute accepts decoded instruction
- id_pc_o  out  XLEN  PC
- id_imm_raw_o  out  INST  instr[31:7], to immediate generator
- id_imm_sel_o  out  3  format: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J
- id_opcode_o  out  7  instr[6:0]
- id_rd_o  out  5  instr[11:7]
- id_rs1_o  out  5  instr[19:15]
- id_rs2_o  out  5  instr[24:20]
- id_funct3_o  out  3  instr[14:12]
- id_funct7_o  out  7  instr[31:25]
- id_illegal_o  out  1  opcode not in supported set

Behaviour:
- Decode table, by opcode:
  - 0110011 → sel 0
  - 0000011, 0010011, 1100111, 1110011 → sel 1
  - 0100011 → sel 2
  - 1100011 → sel 3
  - 0110111, 0010111 → sel 4
  - 1101111 → sel 5
  - any other opcode → sel 0, illegal 1
- Decode is combinational on the incoming word; results are captured into the registers.
- Two entries: output register (OUT) and skid register (SKID), each with a valid bit.
- if_ready_o = !skid_valid. It is a registered signal, with no combinational path from id_ready_i.
- Handshakes: fire_in = if_valid_i & if_ready_o; fire_out = id_valid_o & id_ready_i.
- Each cycle (no flush):
  - If OUT is empty or fire_out: OUT loads SKID if skid_valid (SKID then clears), else loads the incoming instruction if fire_in, else OUT becomes empty.
  - If OUT is held (valid & !id_ready_i) and fire_in: the incoming instruction goes to SKID.
  - If SKID drains into OUT and fire_in in the same cycle: the incoming instruction goes to SKID.
- Latency: 1 cycle, input to id_valid_o, when the stage is empty. Throughput is 1 instruction/cycle with id_ready_i held high.
- Ordering is strictly preserved. No instruction is dropped or duplicated outside flush.
- Outputs hold stable while id_valid_o=1 and id_ready_i=0.
- flush_i=1: next cycle both valid bits are 0 and if_ready_o=1. An input firing in the flush cycle is discarded. Flush has priority over all loads.
- Reset (rst_n_i=0 at clock edge):
  - id_valid_o=0; all data outputs 0; id_imm_sel_o=0; id_illegal_o=0; if_ready_o=1.
  - Reset takes priority over flush and handshakes.
  - Reset mid-stream discards both entries.
- Data registers update only on load, which keeps toggling low.

Test Plan:
- Reset then push 0xFFF10093 (addi x1,x2,-1) at pc 0x100, id_ready_i=1 → next cycle: id_valid_o=1, id_imm_raw_o=0x1FFE201, id_imm_sel_o=1, rd=1, rs1=2, funct3=0, id_pc_o=0x100, illegal=0.
- Back-to-back stream: 0x00512423 (sw x5,8(x2)), 0xFE000EE3 (beq), 0x000010B7 (lui), 0x0000006F (jal), 0x002081B3 (add), one per cycle → sel sequence 2,3,4,5,0, one per cycle; rs2 of the sw = 5.
- Backpressure: id_ready_i=0 while 3 instructions are offered → first held in OUT, second in SKID, if_ready_o=0 on the following cycle, third not accepted. Raise id_ready_i → all three emerge in order with no gap.
- Flush with both entries full plus if_valid_i=1 → next cycle id_valid_o=0, if_ready_o=1; none of the three instructions ever appears at the output.
- Illegal word 0x00000000 → id_illegal_o=1, id_imm_sel_o=0, id_valid_o=1.
- Assert rst_n_i for one cycle with OUT held and SKID full → next cycle id_valid_o=0, if_ready_o=1, outputs zero.

Source files
------------

// File: rtl/id_decode_stage.sv
// IF/ID pipeline stage: decodes the fetched word into register fields and an immediate-format
// select, and buffers it in a 2-entry skid buffer so that if_ready_o is fully registered.
module id_decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned INST = 25
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_inst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [INST-1:0] id_imm_raw_o,
    output logic [2:0]      id_imm_sel_o,
    output logic [6:0]      id_opcode_o,
    output logic [4:0]      id_rd_o,
    output logic [4:0]      id_rs1_o,
    output logic [4:0]      id_rs2_o,
    output logic [2:0]      id_funct3_o,
    output logic [6:0]      id_funct7_o,
    output logic            id_illegal_o
);

    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     out_inst_q, skid_inst_q;
    logic [XLEN-1:0] out_pc_q, skid_pc_q;
    logic [2:0]      out_sel_q, skid_sel_q;
    logic            out_ill_q, skid_ill_q;

    logic [2:0] in_sel;
    logic       in_ill;
    logic       fire_in;
    logic       out_load, skid_load, out_from_skid;

    always_comb begin
        in_sel = 3'd0;
        in_ill = 1'b0;
        case (if_inst_i[6:0])
            7'b0110011: in_sel = 3'd0;
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: in_sel = 3'd1;
            7'b0100011: in_sel = 3'd2;
            7'b1100011: in_sel = 3'd3;
            7'b0110111, 7'b0010111: in_sel = 3'd4;
            7'b1101111: in_sel = 3'd5;
            default: in_ill = 1'b1;
        endcase
    end

    // skid_valid_q alone gates acceptance, so ready never depends on id_ready_i
    assign fire_in = if_valid_i & ~skid_valid_q;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        out_load      = 1'b0;
        skid_load     = 1'b0;
        out_from_skid = 1'b0;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || id_ready_i) begin
            if (skid_valid_q) begin
                out_load      = 1'b1;
                out_from_skid = 1'b1;
                out_valid_d   = 1'b1;
                skid_load     = fire_in;
                skid_valid_d  = fire_in;
            end else if (fire_in) begin
                out_load    = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (fire_in) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            out_sel_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_sel_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (out_load) begin
                out_inst_q <= out_from_skid ? skid_inst_q : if_inst_i;
                out_pc_q   <= out_from_skid ? skid_pc_q   : if_pc_i;
                out_sel_q  <= out_from_skid ? skid_sel_q  : in_sel;
                out_ill_q  <= out_from_skid ? skid_ill_q  : in_ill;
            end
            if (skid_load) begin
                skid_inst_q <= if_inst_i;
                skid_pc_q   <= if_pc_i;
                skid_sel_q  <= in_sel;
                skid_ill_q  <= in_ill;
            end
        end
    end

    assign if_ready_o   = ~skid_valid_q;
    assign id_valid_o   = out_valid_q;
    assign id_pc_o      = out_pc_q;
    assign id_imm_raw_o = out_inst_q[31:7];
    assign id_imm_sel_o = out_sel_q;
    assign id_opcode_o  = out_inst_q[6:0];
    assign id_rd_o      = out_inst_q[11:7];
    assign id_rs1_o     = out_inst_q[19:15];
    assign id_rs2_o     = out_inst_q[24:20];
    assign id_funct3_o  = out_inst_q[14:12];
    assign id_funct7_o  = out_inst_q[31:25];
    assign id_illegal_o = out_ill_q;

endmodule
